// File: rtl/fpnew_lane_join_slice.sv
// ============================================================================
// Module      : fpnew_lane_join_slice
// Description : Broadcasts each operation atomically to per-lane units and
//               joins their in-order results into one boxed slice result.
//               Optional flush support: define FPNEW_LANE_JOIN_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpnew_lane_join_slice #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned FP_WIDTH    = 16,
    parameter int unsigned OUTST_DEPTH = 2,
    parameter int unsigned TAG_WIDTH   = 8,
    localparam int unsigned NUM_LANES  = WIDTH / FP_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          vectorial_op_i,
    input  logic [TAG_WIDTH-1:0]          tag_i,
    input  logic                          flush_i,
    output logic [NUM_LANES-1:0]          lane_in_valid_o,
    input  logic [NUM_LANES-1:0]          lane_in_ready_i,
    input  logic [NUM_LANES-1:0]          lane_out_valid_i,
    output logic [NUM_LANES-1:0]          lane_out_ready_o,
    input  logic [NUM_LANES*FP_WIDTH-1:0] lane_result_i,
    input  logic [NUM_LANES*5-1:0]        lane_status_i,
    input  logic [NUM_LANES-1:0]          lane_ext_bit_i,
    output logic [WIDTH-1:0]              result_o,
    output logic [4:0]                    status_o,
    output logic                          extension_bit_o,
    output logic [TAG_WIDTH-1:0]          tag_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          busy_o
);

    localparam int unsigned c_ptr_w = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int unsigned c_cnt_w = $clog2(OUTST_DEPTH + 1);
    localparam int unsigned c_ent_w = FP_WIDTH + 6;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(OUTST_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(OUTST_DEPTH);

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_last) ? '0 : ptr + 1'b1;
    endfunction

    logic                 w_flush;
    logic                 w_unused;
    logic [NUM_LANES-1:0] w_in_mask;
    logic [NUM_LANES-1:0] w_head_mask;
    logic [NUM_LANES-1:0] w_lane_nempty;
    logic [NUM_LANES-1:0][c_ent_w-1:0] w_lane_head;
    logic                 w_ctl_full;
    logic                 w_ctl_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ext;

    logic [TAG_WIDTH-1:0] r_ctl_tag [OUTST_DEPTH];
    logic                 r_ctl_vec [OUTST_DEPTH];
    logic [c_ptr_w-1:0]   r_ctl_wptr;
    logic [c_ptr_w-1:0]   r_ctl_rptr;
    logic [c_cnt_w-1:0]   r_ctl_cnt;

`ifdef FPNEW_LANE_JOIN_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Lane ext bits above lane 0 are buffered but never consumed.
    assign w_unused = ^{flush_i, w_lane_head};

    assign w_in_mask   = vectorial_op_i ? '1 : NUM_LANES'(1);
    assign w_head_mask = r_ctl_vec[r_ctl_rptr] ? '1 : NUM_LANES'(1);
    assign w_ctl_full  = (r_ctl_cnt == c_cnt_full);
    assign w_ctl_empty = (r_ctl_cnt == '0);

    assign in_ready_o      = !rst_i && !w_flush && !w_ctl_full
                             && (&(lane_in_ready_i | ~w_in_mask));
    assign w_push          = in_valid_i & in_ready_o;
    assign lane_in_valid_o = {NUM_LANES{w_push}} & w_in_mask;

    assign out_valid_o = !rst_i && !w_flush && !w_ctl_empty
                         && (&(w_lane_nempty | ~w_head_mask));
    assign w_pop       = out_valid_o & out_ready_i;
    assign busy_o      = !w_ctl_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_flush) begin
            r_ctl_wptr <= '0;
            r_ctl_rptr <= '0;
            r_ctl_cnt  <= '0;
        end else begin
            if (w_push) r_ctl_wptr <= next_ptr(r_ctl_wptr);
            if (w_pop)  r_ctl_rptr <= next_ptr(r_ctl_rptr);
            r_ctl_cnt <= r_ctl_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_ctl_tag[r_ctl_wptr] <= tag_i;
            r_ctl_vec[r_ctl_wptr] <= vectorial_op_i;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [c_ent_w-1:0] r_mem [OUTST_DEPTH];
        logic [c_ptr_w-1:0] r_wptr;
        logic [c_ptr_w-1:0] r_rptr;
        logic [c_cnt_w-1:0] r_cnt;
        logic               w_lpush;
        logic               w_lpop;

        assign lane_out_ready_o[l] = (r_cnt != c_cnt_full);
        assign w_lane_nempty[l]    = (r_cnt != '0);
        assign w_lane_head[l]      = r_mem[r_rptr];
        assign w_lpush             = lane_out_valid_i[l] & lane_out_ready_o[l];
        assign w_lpop              = w_pop & w_head_mask[l];

        always_ff @(posedge clk_i) begin
            if (rst_i || w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_lpush) r_wptr <= next_ptr(r_wptr);
                if (w_lpop)  r_rptr <= next_ptr(r_rptr);
                r_cnt <= r_cnt + c_cnt_w'(w_lpush) - c_cnt_w'(w_lpop);
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_lpush) begin
                r_mem[r_wptr] <= {lane_result_i[l*FP_WIDTH +: FP_WIDTH],
                                  lane_status_i[l*5 +: 5],
                                  lane_ext_bit_i[l]};
            end
        end
    end

    assign w_ext = w_lane_head[0][0];

    // Untargeted lanes and any padding above the lanes carry lane 0's ext bit.
    always_comb begin
        result_o        = '0;
        status_o        = '0;
        extension_bit_o = 1'b0;
        tag_o           = '0;
        if (out_valid_o) begin
            result_o        = {WIDTH{w_ext}};
            extension_bit_o = w_ext;
            tag_o           = r_ctl_tag[r_ctl_rptr];
            for (int l = 0; l < NUM_LANES; l++) begin
                if (w_head_mask[l]) begin
                    result_o[l*FP_WIDTH +: FP_WIDTH] = w_lane_head[l][c_ent_w-1 -: FP_WIDTH];
                    status_o = status_o | w_lane_head[l][5:1];
                end
            end
        end
    end

endmodule

`default_nettype wire
